// File: rtl/regfile_sb_if.sv
// Register-file bus bundle: read ports, write-back, issue/scoreboard and clear control.
// master drives addresses/write-back/issue/clear; slave returns read data, pend flags and clear status.
interface regfile_sb_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRPORT = 2
);
    localparam int unsigned AW = $clog2(NREG);

    logic [NRPORT*AW-1:0]   i_rs_addr;
    logic [NRPORT*XLEN-1:0] o_rs_data;
    logic [NRPORT-1:0]      o_rs_pend;
    logic [AW-1:0]          i_rd_addr;
    logic [XLEN-1:0]        i_rd_data;
    logic                   i_rd_wren;
    logic [AW-1:0]          i_iss_addr;
    logic                   i_iss_valid;
    logic                   i_clr;
    logic                   o_clr_busy;

    modport master (
        output i_rs_addr, i_rd_addr, i_rd_data, i_rd_wren, i_iss_addr, i_iss_valid, i_clr,
        input  o_rs_data, o_rs_pend, o_clr_busy
    );

    modport slave (
        input  i_rs_addr, i_rd_addr, i_rd_data, i_rd_wren, i_iss_addr, i_iss_valid, i_clr,
        output o_rs_data, o_rs_pend, o_clr_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-ported register file with a per-register pending scoreboard, optional
// write-to-read forwarding and a sequential clear sweep.
// Ports:
//   i_clk      - clock, all state updates on the rising edge
//   i_rst      - synchronous active-high reset
//   bus        - regfile_sb_if slave: combinational reads (o_rs_data/o_rs_pend),
//                write-back (i_rd_*), issue marking (i_iss_*), clear (i_clr/o_clr_busy)
module regfile_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRPORT = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    regfile_sb_if.slave bus
);
    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic {IDLE = 1'b0, CLR = 1'b1} state_t;

    state_t              state;
    state_t              state_next;
    logic [AW-1:0]       cnt;
    logic [AW-1:0]       cnt_next;
    logic                clr_busy;
    logic [XLEN-1:0]     regs [NREG];
    logic [NREG-1:0]     pend;
    logic                wr_en;
    logic                iss_en;
    logic [NRPORT*XLEN-1:0] rs_data_c;
    logic [NRPORT-1:0]      rs_pend_c;

    // Writes and issues only take effect while idle; address 0 is hardwired
    assign wr_en  = bus.i_rd_wren   && (bus.i_rd_addr  != '0) && (state == IDLE);
    assign iss_en = bus.i_iss_valid && (bus.i_iss_addr != '0) && (state == IDLE);

    // FSM state register and sweep counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            clr_busy <= (state_next == CLR);
        end
    end

    // Next-state: sweep starts at 1 (reg 0 is constant) and ends after NREG-1
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.i_clr) begin
                    state_next = CLR;
                    cnt_next   = AW'(1);
                end
            end
            CLR: begin
                cnt_next = cnt + AW'(1);
                if (cnt == AW'(NREG - 1)) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Storage and scoreboard; issue after write so a same-address issue wins
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLR) begin
            regs[cnt] <= '0;
            pend[cnt] <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[bus.i_rd_addr] <= bus.i_rd_data;
                pend[bus.i_rd_addr] <= 1'b0;
            end
            if (iss_en) begin
                pend[bus.i_iss_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports with optional forwarding of the write-back value
    always_comb begin
        rs_data_c = '0;
        rs_pend_c = '0;
        for (int p = 0; p < NRPORT; p++) begin
            if (bus.i_rs_addr[p*AW +: AW] != '0) begin
                if ((BYPASS != 0) && wr_en && (bus.i_rs_addr[p*AW +: AW] == bus.i_rd_addr)) begin
                    rs_data_c[p*XLEN +: XLEN] = bus.i_rd_data;
                    rs_pend_c[p]              = 1'b0;
                end else begin
                    rs_data_c[p*XLEN +: XLEN] = regs[bus.i_rs_addr[p*AW +: AW]];
                    rs_pend_c[p]              = pend[bus.i_rs_addr[p*AW +: AW]];
                end
            end
        end
    end

    assign bus.o_rs_data  = rs_data_c;
    assign bus.o_rs_pend  = rs_pend_c;
    assign bus.o_clr_busy = clr_busy;
endmodule
